// File: rtl/dma_priority_arbiter_if.sv
// Bus-side signals of the DMA priority arbiter, grouped for the arbiter (slave) and its environment (master).
// Software request inputs exist only when DMA_SOFT_REQUEST_EN is defined.
interface dma_priority_arbiter_if;
  logic       masterClear;
  logic [3:0] dreq;
  logic [7:0] commandRegOut;
  logic [3:0] maskRegOut;
  logic       hlda;
  logic       done;
  logic       hrq;
  logic [3:0] dack;
  logic       grant;
  logic [1:0] activeChannel;
  logic [3:0] pendingReq;
`ifdef DMA_SOFT_REQUEST_EN
  logic       softReqLoad;
  logic [2:0] softReqData;

  modport slave (
    input  masterClear, dreq, commandRegOut, maskRegOut, hlda, done, softReqLoad, softReqData,
    output hrq, dack, grant, activeChannel, pendingReq
  );
  modport master (
    output masterClear, dreq, commandRegOut, maskRegOut, hlda, done, softReqLoad, softReqData,
    input  hrq, dack, grant, activeChannel, pendingReq
  );
`else
  modport slave (
    input  masterClear, dreq, commandRegOut, maskRegOut, hlda, done,
    output hrq, dack, grant, activeChannel, pendingReq
  );
  modport master (
    output masterClear, dreq, commandRegOut, maskRegOut, hlda, done,
    input  hrq, dack, grant, activeChannel, pendingReq
  );
`endif
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style request sampling, fixed/rotating priority selection and HRQ/HLDA/DACK handshake.
// Optional software request register is enabled by defining DMA_SOFT_REQUEST_EN.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, REL} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   dreqS_q, dreqS_d;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   oneHot_q, oneHot_d;
  logic [1:0]          top_q, top_d;
  logic [1:0]          chan_q, chan_d;
  logic [1:0]          winner;
  logic                hrq_q, hrq_d;
  logic                grant_q, grant_d;
  logic                clear;
  logic                unusedCmdBits;

  assign clear         = rst_i || bus.masterClear;
  assign dreqS_d       = bus.dreq ^ {NUM_CH{bus.commandRegOut[6]}};
  assign unusedCmdBits = ^{bus.commandRegOut[5], bus.commandRegOut[3], bus.commandRegOut[1:0]};

`ifdef DMA_SOFT_REQUEST_EN
  logic [NUM_CH-1:0] sreq_q, sreq_d;

  // Completing a service clears that channel's software request even if it is being written the same cycle.
  always_comb begin
    sreq_d = sreq_q;
    if (bus.softReqLoad) sreq_d[bus.softReqData[1:0]] = bus.softReqData[2];
    if (state_q == GRANT && bus.done) sreq_d[chan_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (clear) sreq_q <= '0;
    else       sreq_q <= sreq_d;
  end

  assign req = (dreqS_q & ~bus.maskRegOut) | sreq_q;
`else
  assign req = dreqS_q & ~bus.maskRegOut;
`endif

  // Scan from the lowest-priority slot down so the highest-priority requester is written last.
  always_comb begin
    logic [1:0] base;
    logic [1:0] idx;
    base   = bus.commandRegOut[4] ? top_q : 2'd0;
    idx    = 2'd0;
    winner = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q  <= IDLE;
      dreqS_q  <= '0;
      top_q    <= 2'd0;
      chan_q   <= 2'd0;
      hrq_q    <= 1'b0;
      grant_q  <= 1'b0;
      oneHot_q <= '0;
    end else begin
      state_q  <= state_d;
      dreqS_q  <= dreqS_d;
      top_q    <= top_d;
      chan_q   <= chan_d;
      hrq_q    <= hrq_d;
      grant_q  <= grant_d;
      oneHot_q <= oneHot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    top_d   = top_q;
    unique case (state_q)
      IDLE:  if (!bus.commandRegOut[2] && |req) state_d = REQ;
      REQ: begin
        if (!(|req)) begin
          state_d = IDLE;
        end else if (bus.hlda) begin
          state_d = GRANT;
          chan_d  = winner;
        end
      end
      GRANT: begin
        if (bus.done) begin
          state_d = REL;
          if (bus.commandRegOut[4]) top_d = chan_q + 2'd1;
        end else if (!bus.hlda) begin
          state_d = IDLE;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // HRQ rises only after a request has stayed qualified for one full cycle in REQ.
  always_comb begin
    hrq_d    = (state_d == GRANT) || (state_q == REQ && state_d == REQ);
    grant_d  = (state_d == GRANT);
    oneHot_d = grant_d ? (NUM_CH'(1) << chan_d) : '0;
  end

  assign bus.hrq           = hrq_q;
  assign bus.grant         = grant_q;
  assign bus.activeChannel = chan_q;
  assign bus.pendingReq    = req;
  assign bus.dack          = oneHot_q ^ {NUM_CH{~bus.commandRegOut[7]}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: vector table, directed corner cases and a randomized
// run against a cycle-level behavioural model of the request/priority/handshake rules.
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_priority_arbiter_if bus();

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] dreq;
    logic       hlda;
    logic       done;
    logic       expHrq;
    logic       expGrant;
    logic [1:0] expCh;
    logic [3:0] expDack;
    logic [3:0] expPend;
  } vec_t;

  vec_t vecs[8];

  localparam int P_IDLE  = 0;
  localparam int P_ASK   = 1;
  localparam int P_SERVE = 2;
  localparam int P_REL   = 3;

  int         mPhase;
  int         mAge;
  int         mTop;
  int         mCh;
  logic [3:0] mSample;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] dreq, input logic [7:0] cmd, input logic [3:0] mask,
                               input logic hlda, input logic done);
    bus.dreq          = dreq;
    bus.commandRegOut = cmd;
    bus.maskRegOut    = mask;
    bus.hlda          = hlda;
    bus.done          = done;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitGrant(input string name);
    int n;
    n = 0;
    while (bus.grant !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({name, "_grantSeen"}, int'(bus.grant), 1);
  endtask

  task automatic pulseDone(input string name);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checkOutput({name, "_relGrant"}, int'(bus.grant), 0);
    checkOutput({name, "_relHrq"}, int'(bus.hrq), 0);
  endtask

  function automatic int pickWinner(input logic [3:0] r, input int first);
    for (int k = 0; k < 4; k++) begin
      if (r[(first + k) % 4]) return (first + k) % 4;
    end
    return 0;
  endfunction

  task automatic modelReset();
    mPhase  = P_IDLE;
    mAge    = 0;
    mTop    = 0;
    mCh     = 0;
    mSample = 4'b0000;
  endtask

  task automatic modelStep(input logic [3:0] dreq, input logic [7:0] cmd, input logic [3:0] mask,
                           input logic hlda, input logic done);
    logic [3:0] r;
    r = mSample & ~mask;
    case (mPhase)
      P_IDLE: begin
        if (!cmd[2] && r != 4'b0000) begin
          mPhase = P_ASK;
          mAge   = 0;
        end
      end
      P_ASK: begin
        if (r == 4'b0000) mPhase = P_IDLE;
        else if (hlda) begin
          mCh    = pickWinner(r, cmd[4] ? mTop : 0);
          mPhase = P_SERVE;
        end else mAge++;
      end
      P_SERVE: begin
        if (done) begin
          if (cmd[4]) mTop = (mCh + 1) % 4;
          mPhase = P_REL;
        end else if (!hlda) mPhase = P_IDLE;
      end
      default: mPhase = P_IDLE;
    endcase
    mSample = dreq ^ {4{cmd[6]}};
  endtask

  initial begin
    logic [3:0] rDreq;
    logic [7:0] rCmd;
    logic [3:0] rMask;
    logic       rHlda;
    logic       rDone;
    logic       rMc;
    logic [3:0] expDack;

    bus.masterClear = 1'b0;
`ifdef DMA_SOFT_REQUEST_EN
    bus.softReqLoad = 1'b0;
    bus.softReqData = 3'b000;
`endif

    vecs[0] = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0101};
    vecs[1] = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0101};
    vecs[2] = '{4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0101};
    vecs[3] = '{4'b0101, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b1110, 4'b0101};
    vecs[4] = '{4'b0101, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b1110, 4'b0101};
    vecs[5] = '{4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0101};
    vecs[6] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0000};
    vecs[7] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0000};

    // Reset values, then the basic fixed-priority service from the vector table
    applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0);
    doReset();
    checkOutput("rst_hrq", int'(bus.hrq), 0);
    checkOutput("rst_grant", int'(bus.grant), 0);
    checkOutput("rst_ch", int'(bus.activeChannel), 0);
    checkOutput("rst_dack", int'(bus.dack), 'hF);
    checkOutput("rst_pend", int'(bus.pendingReq), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dreq, 8'h00, 4'b0000, vecs[i].hlda, vecs[i].done);
      tick();
      checkOutput($sformatf("vec%0d_hrq", i), int'(bus.hrq), int'(vecs[i].expHrq));
      checkOutput($sformatf("vec%0d_grant", i), int'(bus.grant), int'(vecs[i].expGrant));
      checkOutput($sformatf("vec%0d_ch", i), int'(bus.activeChannel), int'(vecs[i].expCh));
      checkOutput($sformatf("vec%0d_dack", i), int'(bus.dack), int'(vecs[i].expDack));
      checkOutput($sformatf("vec%0d_pend", i), int'(bus.pendingReq), int'(vecs[i].expPend));
    end

    // Rotating priority with all channels requesting
    applyStimulus(4'b1111, 8'h10, 4'b0000, 1'b1, 1'b0);
    doReset();
    for (int k = 0; k < 5; k++) begin
      waitGrant($sformatf("rot%0d", k));
      checkOutput($sformatf("rot%0d_ch", k), int'(bus.activeChannel), k % 4);
      pulseDone($sformatf("rot%0d", k));
    end

    // A higher-priority request arriving mid-service does not preempt
    applyStimulus(4'b1000, 8'h00, 4'b0000, 1'b1, 1'b0);
    doReset();
    waitGrant("nopre");
    checkOutput("nopre_ch3", int'(bus.activeChannel), 3);
    bus.dreq = 4'b1001;
    tick();
    tick();
    tick();
    checkOutput("nopre_stillGrant", int'(bus.grant), 1);
    checkOutput("nopre_stillCh3", int'(bus.activeChannel), 3);
    pulseDone("nopre");
    waitGrant("nopre_next");
    checkOutput("nopre_nextCh0", int'(bus.activeChannel), 0);

    // Masked request stays invisible; unmasking raises HRQ two cycles later
    applyStimulus(4'b0001, 8'h00, 4'b0001, 1'b0, 1'b0);
    doReset();
    tick();
    tick();
    tick();
    tick();
    checkOutput("mask_hrq0", int'(bus.hrq), 0);
    checkOutput("mask_pend0", int'(bus.pendingReq), 0);
    bus.maskRegOut = 4'b0000;
    #1;
    checkOutput("mask_pendLive", int'(bus.pendingReq), 1);
    tick();
    checkOutput("mask_hrqEarly", int'(bus.hrq), 0);
    tick();
    checkOutput("mask_hrq1", int'(bus.hrq), 1);

    // Active-low DREQ and active-high DACK
    applyStimulus(4'b1101, 8'hC0, 4'b0000, 1'b1, 1'b0);
    doReset();
    checkOutput("pol_idleDack", int'(bus.dack), 0);
    waitGrant("pol");
    checkOutput("pol_ch1", int'(bus.activeChannel), 1);
    checkOutput("pol_dack", int'(bus.dack), 'h2);

    // HLDA dropped during service aborts without moving the rotation pointer; reset mid-service
    applyStimulus(4'b0110, 8'h10, 4'b0000, 1'b1, 1'b0);
    doReset();
    waitGrant("abort");
    checkOutput("abort_ch1", int'(bus.activeChannel), 1);
    bus.hlda = 1'b0;
    tick();
    checkOutput("abort_grant", int'(bus.grant), 0);
    checkOutput("abort_hrq", int'(bus.hrq), 0);
    bus.hlda = 1'b1;
    waitGrant("abort_again");
    checkOutput("abort_topKept", int'(bus.activeChannel), 1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_hrq", int'(bus.hrq), 0);
    checkOutput("midrst_grant", int'(bus.grant), 0);
    checkOutput("midrst_ch", int'(bus.activeChannel), 0);
    checkOutput("midrst_dack", int'(bus.dack), 'hF);
    rst = 1'b0;

    // Randomized run against the behavioural model
    rDreq = 4'b0000;
    rCmd  = 8'h00;
    rMask = 4'b0000;
    applyStimulus(rDreq, rCmd, rMask, 1'b0, 1'b0);
    doReset();
    modelReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) rDreq = 4'($urandom);
      if ($urandom_range(0, 31) == 0)
        rCmd = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0,
                ($urandom_range(0, 5) == 0), 2'b00};
      if ($urandom_range(0, 15) == 0) rMask = 4'($urandom);
      if (bus.hrq) rHlda = ($urandom_range(0, 9) != 0);
      else         rHlda = ($urandom_range(0, 5) == 0);
      rDone = (bus.grant && $urandom_range(0, 3) == 0) || ($urandom_range(0, 40) == 0);
      rMc   = ($urandom_range(0, 199) == 0);

      applyStimulus(rDreq, rCmd, rMask, rHlda, rDone);
      bus.masterClear = rMc;
      if (rMc) modelReset();
      else     modelStep(rDreq, rCmd, rMask, rHlda, rDone);
      tick();
      bus.masterClear = 1'b0;

      expDack = ((mPhase == P_SERVE) ? (4'b0001 << mCh) : 4'b0000) ^ {4{~rCmd[7]}};
      checkOutput($sformatf("rand%0d_hrq", cyc), int'(bus.hrq),
                  int'((mPhase == P_SERVE) || (mPhase == P_ASK && mAge >= 1)));
      checkOutput($sformatf("rand%0d_grant", cyc), int'(bus.grant), int'(mPhase == P_SERVE));
      checkOutput($sformatf("rand%0d_ch", cyc), int'(bus.activeChannel), mCh);
      checkOutput($sformatf("rand%0d_dack", cyc), int'(bus.dack), int'(expDack));
      checkOutput($sformatf("rand%0d_pend", cyc), int'(bus.pendingReq), int'(mSample & ~rMask));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
